cordic_seq_fsm: RTL and testbench

Sequencing controller for the iterative CORDIC datapath. It accepts a start request and latches the operation (sin/cos) and quadrant from range reduction. It then steps the shared add/subtract unit through `N_ITER` micro-rotations, producing the register-load enables and the iteration index. At completion it drives the select of the output x/y swap multiplexer and holds the result valid until the consumer acknowledges.

---
 rtl/cordic_pkg.sv | 25 ++
 rtl/cordic_iter_counter.sv | 26 ++
 rtl/cordic_seq_fsm.sv | 117 +++++++++++
 tb/tb_cordic_seq_fsm.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and defaults for the CORDIC sequencing controller.
package cordic_pkg;

  localparam int N_ITER_DEF = 16;
  localparam int CNT_W_DEF  = 4;

  localparam logic OP_COS = 1'b0;
  localparam logic OP_SIN = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_INIT,
    S_ITER_START,
    S_ITER_WAIT,
    S_ITER_LOAD,
    S_FINAL,
    S_DONE
  } state_t;

  // Straight (1) when the operation and the low quadrant bit agree, crossed otherwise.
  function automatic logic swap_sel(input logic op, input logic rg0);
    return ~(op ^ rg0);
  endfunction

endpackage

// File: rtl/cordic_iter_counter.sv
// Iteration index counter: clear, saturating increment, terminal-count flag.
module cordic_iter_counter
  import cordic_pkg::*;
#(
  parameter int N_ITER = N_ITER_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  // Terminal count is the last micro-rotation index.
  assign tc = (cnt == CNT_W'(N_ITER - 1));

  // Counter register; an increment at terminal count is dropped so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (inc && !tc)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/cordic_seq_fsm.sv
// Sequencer for the iterative CORDIC datapath: start capture, N_ITER
// add/subtract micro-rotations, result load and consumer handshake.
module cordic_seq_fsm
  import cordic_pkg::*;
#(
  parameter int N_ITER = N_ITER_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beg_fsm_cordic,
  input  logic             ack_fsm_cordic,
  input  logic             operation,
  input  logic [1:0]       shift_region_flag,
  input  logic             ready_add_subt,
  output logic             beg_add_subt,
  output logic             ack_add_subt,
  output logic             load_init,
  output logic             load_iter,
  output logic             load_result,
  output logic             sel_swap,
  output logic [CNT_W-1:0] cont_iter,
  output logic             ready_cordic,
  output logic             busy
);

  state_t     state, state_nxt;
  logic       op_q;
  logic [1:0] reg_q;
  logic       capture;
  logic       last_iter;
  logic       unused_reg_hi;

  assign capture       = (state == S_IDLE) && beg_fsm_cordic;
  assign unused_reg_hi = reg_q[1];

  // Swap select comes only from the captured registers, so it is stable for the
  // whole operation and after it, until the next start is accepted.
  assign sel_swap = swap_sel(op_q, reg_q[0]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Operation and quadrant captured on the accepted start edge only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= OP_COS;
      reg_q <= 2'b00;
    end else if (capture) begin
      op_q  <= operation;
      reg_q <= shift_region_flag;
    end
  end

  // Next state and Moore strobes decoded from the current state.
  always_comb begin
    state_nxt    = state;
    beg_add_subt = 1'b0;
    ack_add_subt = 1'b0;
    load_init    = 1'b0;
    load_iter    = 1'b0;
    load_result  = 1'b0;
    ready_cordic = 1'b0;
    busy         = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (beg_fsm_cordic) state_nxt = S_LOAD_INIT;
      end
      S_LOAD_INIT: begin
        load_init = 1'b1;
        state_nxt = S_ITER_START;
      end
      S_ITER_START: begin
        beg_add_subt = 1'b1;
        state_nxt    = S_ITER_WAIT;
      end
      S_ITER_WAIT: begin
        if (ready_add_subt) state_nxt = S_ITER_LOAD;
      end
      S_ITER_LOAD: begin
        load_iter    = 1'b1;
        ack_add_subt = 1'b1;
        state_nxt    = last_iter ? S_FINAL : S_ITER_START;
      end
      S_FINAL: begin
        load_result = 1'b1;
        state_nxt   = S_DONE;
      end
      S_DONE: begin
        ready_cordic = 1'b1;
        // A simultaneous start is not taken here; IDLE sees it next cycle.
        if (ack_fsm_cordic) state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  cordic_iter_counter #(
    .N_ITER (N_ITER),
    .CNT_W  (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (load_init),
    .inc (load_iter),
    .cnt (cont_iter),
    .tc  (last_iter)
  );

endmodule

// File: tb/tb_cordic_seq_fsm.sv
// Directed plus randomized checks of the CORDIC sequencer against a cycle-count
// reference model, on a default instance (16 iterations) and a 2-iteration one.
module tb_cordic_seq_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 1: default parameters
  logic       beg1, ack1, op1, rdy1;
  logic [1:0] rg1;
  logic       bas1, aas1, li1, lit1, lr1, sel1, rc1, busy1;
  logic [3:0] cnt1;
  // Instance 2: N_ITER=2, CNT_W=1
  logic       beg2, ack2, op2, rdy2;
  logic [1:0] rg2;
  logic       bas2, aas2, li2, lit2, lr2, sel2, rc2, busy2;
  logic [0:0] cnt2;

  int vectors = 0;
  int miscompares = 0;

  cordic_seq_fsm u_dut (
    .clk(clk), .rst(rst), .beg_fsm_cordic(beg1), .ack_fsm_cordic(ack1),
    .operation(op1), .shift_region_flag(rg1), .ready_add_subt(rdy1),
    .beg_add_subt(bas1), .ack_add_subt(aas1), .load_init(li1), .load_iter(lit1),
    .load_result(lr1), .sel_swap(sel1), .cont_iter(cnt1), .ready_cordic(rc1), .busy(busy1)
  );

  cordic_seq_fsm #(.N_ITER(2), .CNT_W(1)) u_dut2 (
    .clk(clk), .rst(rst), .beg_fsm_cordic(beg2), .ack_fsm_cordic(ack2),
    .operation(op2), .shift_region_flag(rg2), .ready_add_subt(rdy2),
    .beg_add_subt(bas2), .ack_add_subt(aas2), .load_init(li2), .load_iter(lit2),
    .load_result(lr2), .sel_swap(sel2), .cont_iter(cnt2), .ready_cordic(rc2), .busy(busy2)
  );

  typedef struct {
    logic       bas, aas, li, lit, lr, sel;
    logic [3:0] cnt;
    logic       rdyc, busy;
  } obs_t;

  function automatic obs_t get_obs(input bit w);
    obs_t o;
    if (w) begin
      o.bas = bas2; o.aas = aas2; o.li = li2; o.lit = lit2; o.lr = lr2;
      o.sel = sel2; o.cnt = {3'b000, cnt2}; o.rdyc = rc2; o.busy = busy2;
    end else begin
      o.bas = bas1; o.aas = aas1; o.li = li1; o.lit = lit1; o.lr = lr1;
      o.sel = sel1; o.cnt = cnt1; o.rdyc = rc1; o.busy = busy1;
    end
    return o;
  endfunction

  function automatic logic [11:0] pack_obs(input obs_t o);
    return {o.bas, o.aas, o.li, o.lit, o.lr, o.sel, o.cnt, o.rdyc, o.busy};
  endfunction

  // Drive the selected instance; the other one sees idle handshakes.
  task automatic drive(input bit w, input logic b, input logic a, input logic o,
                       input logic [1:0] r, input logic rd);
    if (w) begin
      beg2 = b; ack2 = a; op2 = o; rg2 = r; rdy2 = rd;
      beg1 = 1'b0; ack1 = 1'b0; rdy1 = 1'b0;
    end else begin
      beg1 = b; ack1 = a; op1 = o; rg1 = r; rdy1 = rd;
      beg2 = 1'b0; ack2 = 1'b0; rdy2 = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One complete operation. Called at a negedge with the instance in IDLE.
  // Model: LOAD_INIT in cycle 1, each iteration 3 cycles plus its adder delay,
  // then FINAL and DONE; start/ack/ready noise outside their sampling states.
  task automatic run_op(input bit w, input logic op, input logic [1:0] rg,
                        input int dly[$], input int hold, input bit ackbeg);
    int n, sum, rexp, first_rdy, init_cyc, lr_cyc, rem;
    int nbeg, nack, nli, nlit, nlr, widerr, busyerr, selerr;
    bit pend;
    logic esel, rd;
    obs_t o, p;
    n = w ? 2 : 16;
    sum = 0;
    for (int i = 0; i < n; i++) sum += dly[i % dly.size()];
    rexp = 3 * n + 3 + sum;
    esel = ~(op ^ rg[0]);
    first_rdy = -1; init_cyc = -1; lr_cyc = -1; rem = 0; pend = 0;
    nbeg = 0; nack = 0; nli = 0; nlit = 0; nlr = 0; widerr = 0; busyerr = 0; selerr = 0;
    p = '{default: '0};
    o = '{default: '0};
    drive(w, 1'b1, 1'b0, op, rg, 1'b0);
    for (int cyc = 1; cyc <= rexp + hold; cyc++) begin
      @(negedge clk);
      o = get_obs(w);
      if (o.bas) begin
        chk("iter_index", 32'(o.cnt), nbeg);
        nbeg++;
      end
      if (o.aas) nack++;
      if (o.li)  begin nli++; if (init_cyc < 0) init_cyc = cyc; end
      if (o.lit) nlit++;
      if (o.lr)  begin nlr++; if (lr_cyc < 0) lr_cyc = cyc; end
      if ((o.bas && p.bas) || (o.aas && p.aas) || (o.li && p.li) ||
          (o.lit && p.lit) || (o.lr && p.lr)) widerr++;
      if (o.rdyc && first_rdy < 0) first_rdy = cyc;
      if (o.busy !== 1'b1) busyerr++;
      if (o.sel !== esel) selerr++;
      // Adder responder: ready during the (delay+1)-th cycle after the start pulse.
      if (o.bas) begin
        rem = dly[(nbeg - 1) % dly.size()] + 1;
        pend = 1'b1;
        rd = 1'b0;
      end else if (pend) begin
        rem--;
        rd = (rem == 0);
        if (rem == 0) pend = 1'b0;
      end else begin
        rd = 1'($urandom_range(0, 1));
      end
      drive(w, 1'($urandom_range(0, 1)),
            (cyc < rexp) ? 1'($urandom_range(0, 1)) : 1'b0,
            1'($urandom), 2'($urandom), rd);
      p = o;
    end
    chk("ready_cycle", first_rdy, rexp);
    chk("load_init_cycle", init_cyc, 1);
    chk("load_result_cycle", lr_cyc, rexp - 1);
    chk("beg_pulses", nbeg, n);
    chk("iter_loads", nlit, n);
    chk("ack_pulses", nack, n);
    chk("load_init_pulses", nli, 1);
    chk("load_result_pulses", nlr, 1);
    chk("strobe_width", widerr, 0);
    chk("busy_held", busyerr, 0);
    chk("sel_swap_stable", selerr, 0);
    chk("ready_hold", 32'(o.rdyc), 1);
    drive(w, 1'(ackbeg), 1'b1, 1'($urandom), 2'($urandom), 1'b0);
    @(negedge clk);
    o = get_obs(w);
    chk("idle_after_ack_busy", 32'(o.busy), 0);
    chk("idle_after_ack_ready", 32'(o.rdyc), 0);
    chk("idle_sel_swap", 32'(o.sel), 32'(esel));
  endtask

  initial begin
    int q[$];
    obs_t o;
    bit hit, pb;

    // Reset state on both instances
    rst = 1'b1;
    beg1 = 0; ack1 = 0; op1 = 0; rg1 = 0; rdy1 = 0;
    beg2 = 0; ack2 = 0; op2 = 0; rg2 = 0; rdy2 = 0;
    repeat (2) @(negedge clk);
    chk("reset_state_16", 32'(pack_obs(get_obs(0))), 32'h040);
    chk("reset_state_2", 32'(pack_obs(get_obs(1))), 32'h040);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait cosine, region 00: straight swap, ready at 51
    q = '{0};
    run_op(0, 1'b0, 2'b00, q, 3, 0);
    // Adder latency pattern 0,3,1,7
    q = '{0, 3, 1, 7};
    run_op(0, 1'b0, 2'b00, q, 0, 0);
    // Sine with region 00 -> crossed
    q = '{0};
    run_op(0, 1'b1, 2'b00, q, 0, 0);
    // Sine with region 01 -> straight; ack and start together in DONE
    run_op(0, 1'b1, 2'b01, q, 0, 1);
    // Restart taken from IDLE, then ready held through a long ack-low stretch
    q = '{2};
    run_op(0, 1'b0, 2'b11, q, 20, 0);

    // Asynchronous reset in ITER_WAIT at index 5
    drive(0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
    hit = 0; pb = 0;
    for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
      @(negedge clk);
      o = get_obs(0);
      if (o.bas && o.cnt == 4'd5) hit = 1;
      drive(0, 1'b0, 1'b0, 1'b0, 2'b00, pb);
      pb = o.bas;
    end
    chk("reach_iter5", 32'(hit), 1);
    @(negedge clk);
    o = get_obs(0);
    chk("pre_reset_wait", 32'({o.busy, o.cnt}), 32'({1'b1, 4'd5}));
    chk("pre_reset_sel", 32'(o.sel), 0);
    rst = 1'b1;
    #1;
    chk("reset_async", 32'(pack_obs(get_obs(0))), 32'h040);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 32'(pack_obs(get_obs(0))), 32'h040);
    q = '{1};
    run_op(0, 1'b1, 2'b10, q, 1, 0);

    // Two-iteration instance: counter 0,1 and ready at 9
    q = '{0};
    run_op(1, 1'b0, 2'b00, q, 2, 0);
    q = '{1, 4};
    run_op(1, 1'b1, 2'b10, q, 0, 0);

    // Randomized operations
    for (int r = 0; r < 8; r++) begin
      int m;
      q.delete();
      m = $urandom_range(1, 4);
      for (int j = 0; j < m; j++) q.push_back(int'($urandom_range(0, 7)));
      run_op(1'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), q,
             int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    drive(0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
